// File: rtl/transpose_pkg.sv
// Shared types and helpers for the frame-buffer transpose controller.
// Holds the FSM state encoding and the counter/address width helper.
package transpose_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RD   = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Width needed to index n items; never below 1 so degenerate 1-wide dims still get a bit.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/transpose_ctrl_raster_cnt.sv
// 2-D wrap counter: inner index runs 0..INNER_N-1, then outer advances; both wrap to 0 after last.
// Advances one step per cycle while en_i is high; last_o flags the final position combinationally.
module transpose_ctrl_raster_cnt
  import transpose_pkg::*;
#(
  parameter int INNER_N = 4,
  parameter int OUTER_N = 4,
  localparam int IW = addr_width(INNER_N),
  localparam int OW = addr_width(OUTER_N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          en_i,
  output logic [IW-1:0] inner_o,
  output logic [OW-1:0] outer_o,
  output logic          last_o
);

  localparam logic [IW-1:0] INNER_MAX = IW'(INNER_N - 1);
  localparam logic [OW-1:0] OUTER_MAX = OW'(OUTER_N - 1);

  logic [IW-1:0] inner_q, inner_d;
  logic [OW-1:0] outer_q, outer_d;
  logic          inner_last;
  logic          outer_last;

  assign inner_last = (inner_q == INNER_MAX);
  assign outer_last = (outer_q == OUTER_MAX);

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (en_i) begin
      if (inner_last) begin
        inner_d = '0;
        outer_d = outer_last ? '0 : outer_q + 1'b1;
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign inner_o = inner_q;
  assign outer_o = outer_q;
  assign last_o  = inner_last && outer_last;

endmodule

// File: rtl/transpose_ctrl.sv
// Frame transpose: fills a buffer row-major at 1 pixel/cycle, drains column-major at 2 cycles/pixel,
// stalling in EMIT while Out1_RDY is low. TRANSPOSE_CTRL_FRAME_CNT_EN adds a frame_count output.
module transpose_ctrl
  import transpose_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              In1_SEND,
  input  logic [7:0]        In1_DATA,
  output logic              In1_ACK,
  input  logic              Out1_RDY,
  output logic              Out1_SEND,
  output logic [7:0]        Out1_DATA,
  output logic [15:0]       Out1_COUNT,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              frame_done,
  output logic              busy
`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  localparam int CW = addr_width(IMG_W);
  localparam int RW = addr_width(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

  state_t        state_q, state_d;
  logic          fill_en, drain_en;
  logic          fill_last, drain_last;
  logic [CW-1:0] fill_col;
  logic [RW-1:0] fill_row;
  logic [RW-1:0] drain_r;
  logic [CW-1:0] drain_c;

  transpose_ctrl_raster_cnt #(
    .INNER_N (IMG_W),
    .OUTER_N (IMG_H)
  ) u_fill_cnt (
    .CLK     (CLK),
    .RESET   (RESET),
    .en_i    (fill_en),
    .inner_o (fill_col),
    .outer_o (fill_row),
    .last_o  (fill_last)
  );

  transpose_ctrl_raster_cnt #(
    .INNER_N (IMG_H),
    .OUTER_N (IMG_W)
  ) u_drain_cnt (
    .CLK     (CLK),
    .RESET   (RESET),
    .en_i    (drain_en),
    .inner_o (drain_r),
    .outer_o (drain_c),
    .last_o  (drain_last)
  );

  // Handshakes are gated by RESET so nothing is accepted while the flops are held clear.
  always_comb begin
    state_d   = state_q;
    fill_en   = 1'b0;
    drain_en  = 1'b0;
    In1_ACK   = 1'b0;
    mem_we    = 1'b0;
    Out1_SEND = 1'b0;
    if (!RESET) begin
      case (state_q)
        FILL: begin
          if (In1_SEND) begin
            fill_en = 1'b1;
            In1_ACK = 1'b1;
            mem_we  = 1'b1;
            if (fill_last) state_d = RD;
          end
        end
        RD: state_d = EMIT;
        EMIT: begin
          if (Out1_RDY) begin
            drain_en  = 1'b1;
            Out1_SEND = 1'b1;
            state_d   = drain_last ? FILL : RD;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= FILL;
    else       state_q <= state_d;
  end

  assign mem_waddr  = ADDR_W'(fill_row) * ROW_STRIDE + ADDR_W'(fill_col);
  assign mem_wdata  = In1_DATA;
  assign mem_raddr  = ADDR_W'(drain_r) * ROW_STRIDE + ADDR_W'(drain_c);
  assign Out1_DATA  = Out1_SEND ? mem_rdata : 8'h00;
  assign Out1_COUNT = 16'h0001;
  assign frame_done = drain_en && drain_last;
  assign busy       = (state_q != FILL) || (fill_col != '0) || (fill_row != '0);

`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           frame_count_q <= 16'h0000;
    else if (frame_done) frame_count_q <= frame_count_q + 16'h0001;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_transpose_ctrl.sv
// Directed bench: 4x4 and 3x2 transposes with backpressure, mid-fill reset and back-to-back frames.
`timescale 1ns/1ps
module tb_transpose_ctrl;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 4x4 instance
  logic        a_send, a_ack, a_rdy, a_osend, a_we, a_done, a_busy;
  logic [7:0]  a_data, a_odata, a_wdata, a_rdata;
  logic [15:0] a_cnt;
  logic [3:0]  a_waddr, a_raddr;
  logic [7:0]  mem_a [0:15];
  // 3x2 instance
  logic        b_send, b_ack, b_rdy, b_osend, b_we, b_done, b_busy;
  logic [7:0]  b_data, b_odata, b_wdata, b_rdata;
  logic [15:0] b_cnt;
  logic [2:0]  b_waddr, b_raddr;
  logic [7:0]  mem_b [0:7];
`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  transpose_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) dut_a (
    .CLK(clk), .RESET(rst), .In1_SEND(a_send), .In1_DATA(a_data), .In1_ACK(a_ack),
    .Out1_RDY(a_rdy), .Out1_SEND(a_osend), .Out1_DATA(a_odata), .Out1_COUNT(a_cnt),
    .mem_we(a_we), .mem_waddr(a_waddr), .mem_wdata(a_wdata), .mem_raddr(a_raddr),
    .mem_rdata(a_rdata), .frame_done(a_done), .busy(a_busy)
`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
    , .frame_count(a_fc)
`endif
  );

  transpose_ctrl #(.IMG_W(3), .IMG_H(2), .ADDR_W(3)) dut_b (
    .CLK(clk), .RESET(rst), .In1_SEND(b_send), .In1_DATA(b_data), .In1_ACK(b_ack),
    .Out1_RDY(b_rdy), .Out1_SEND(b_osend), .Out1_DATA(b_odata), .Out1_COUNT(b_cnt),
    .mem_we(b_we), .mem_waddr(b_waddr), .mem_wdata(b_wdata), .mem_raddr(b_raddr),
    .mem_rdata(b_rdata), .frame_done(b_done), .busy(b_busy)
`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
    , .frame_count(b_fc)
`endif
  );

  // Frame buffers with one-cycle registered read
  always @(posedge clk) begin
    if (a_we) mem_a[a_waddr] <= a_wdata;
    a_rdata <= mem_a[a_raddr];
    if (b_we) mem_b[b_waddr] <= b_wdata;
    b_rdata <= mem_b[b_raddr];
  end

  vec_t va [16];
  vec_t vb [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; inputs driven there, outputs sampled 2ns later.
  task automatic fill_a(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      a_send = 1'b1;
      a_data = base + va[i].din;
      #2;
      chk("fill_ack", a_ack, 1);
      chk("fill_we_waddr", {a_we, a_waddr}, {1'b1, 4'(i)});
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_a(input logic [7:0] base, input int stall_at, input logic hold);
    int k = 0;
    int stall = 0;
    int guard = 0;
    while (k < 16 && guard < 200) begin
      guard++;
      a_send = hold;
      a_data = 8'hEE;
      a_rdy  = !(k == stall_at && stall < 10);
      #2;
      if (hold) chk("drain_no_ack", {a_ack, a_we}, 0);
      if (!a_rdy) begin
        stall++;
        chk("stall_quiet", {a_osend, a_odata}, 0);
      end else if (a_osend) begin
        chk("out_data", a_odata, base + va[k].exp);
        chk("done_flag", a_done, (k == 15));
        if (k == 8) chk("busy_drain", a_busy, 1);
        k++;
      end else begin
        chk("idle_data", {a_osend, a_odata, a_done}, 0);
      end
      @(posedge clk); #1;
    end
    if (k < 16) chk("drain_timeout", k, 16);
    a_rdy = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_a [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    logic [7:0] exp_b [6]  = '{0, 3, 1, 4, 2, 5};
    int k;
    int guard;
    for (int i = 0; i < 16; i++) va[i] = '{din: 8'(i), exp: exp_a[i]};
    for (int i = 0; i < 6; i++)  vb[i] = '{din: 8'(i), exp: exp_b[i]};

    a_send = 1'b1; a_data = 8'h55; a_rdy = 1'b1;
    b_send = 1'b1; b_data = 8'h55; b_rdy = 1'b1;
    #12;
    chk("rst_ack", a_ack, 0);
    chk("rst_we", a_we, 0);
    chk("rst_osend", {a_osend, a_odata}, 0);
    chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_count", a_cnt, 16'h1);
    chk("rst_b", {b_ack, b_we, b_osend, b_done, b_busy}, 0);
    chk("rst_count_b", b_cnt, 16'h1);
    a_send = 1'b0; b_send = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back frames with In1_SEND held high; the second with a 10-cycle stall at pixel 5
    fill_a(8'd0, 16);
    drain_a(8'd0, -1, 1'b1);
    fill_a(8'd16, 16);
    drain_a(8'd16, 5, 1'b1);
    fill_a(8'd32, 16);
    drain_a(8'd32, -1, 1'b0);
    a_send = 1'b0;
    chk("idle_busy", a_busy, 0);

`ifdef TRANSPOSE_CTRL_FRAME_CNT_EN
    chk("frame_count_3", a_fc, 16'd3);
    force dut_a.frame_count_q = 16'hFFFF;
    #1;
    release dut_a.frame_count_q;
    @(posedge clk); #1;
    fill_a(8'd64, 16);
    drain_a(8'd64, -1, 1'b0);
    a_send = 1'b0;
    chk("frame_count_wrap", a_fc, 16'd0);
`endif

    // Reset mid-fill: partial frame must be discarded
    fill_a(8'd200, 7);
    chk("part_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_ack", {a_ack, a_we}, 0);
    a_send = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_a(8'd100, 16);
    drain_a(8'd100, -1, 1'b0);
    a_send = 1'b0;

    // 3x2 frame
    for (int i = 0; i < 6; i++) begin
      b_send = 1'b1;
      b_data = vb[i].din;
      #2;
      chk("b_fill", {b_ack, b_we, b_waddr}, {2'b11, 3'(i)});
      @(posedge clk); #1;
    end
    b_send = 1'b0;
    k = 0;
    guard = 0;
    while (k < 6 && guard < 50) begin
      guard++;
      #2;
      if (b_osend) begin
        chk("b_out_data", b_odata, vb[k].exp);
        chk("b_done_flag", b_done, (k == 5));
        k++;
      end else begin
        chk("b_idle", {b_odata, b_done}, 0);
      end
      @(posedge clk); #1;
    end
    if (k < 6) chk("b_drain_timeout", k, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/transpose_ctrl.md
TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 4, input image width in pixels (>=1).
REQ-002 SHALL have parameter IMG_H, default 4, input image height in pixels (>=1).
REQ-003 SHALL have parameter ADDR_W, default 4, frame-buffer address width, ceil(log2(IMG_W*IMG_H)), minimum 1.
REQ-004 SHALL use reset RESET, asynchronous, active-high, and clock CLK.
REQ-005 SHALL have ports, in order:
- CLK  in  1  clock
- RESET  in  1  async active-high reset
- In1_SEND  in  1  input token available
- In1_DATA  in  8  input pixel
- In1_ACK  out  1  input token consumed, one-cycle pulse
- Out1_RDY  in  1  downstream can accept a token
- Out1_SEND  out  1  output token valid, one-cycle pulse
- Out1_DATA  out  8  output pixel
- Out1_COUNT  out  16  tokens per send, constant 1
- mem_we  out  1  frame-buffer write strobe
- mem_waddr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- mem_raddr  out  ADDR_W  read address
- mem_rdata  in  8  read data, one cycle after mem_raddr
- frame_done  out  1  one-cycle pulse on the last output pixel
- busy  out  1  high whenever any pixel of the current frame has been written or is still to be drained

Function
REQ-006 SHALL implement FSM states FILL, RD, EMIT; the reset state is FILL.
REQ-007 SHALL, in FILL with In1_SEND=1, assert In1_ACK and mem_we in the same cycle, with mem_waddr=row*IMG_W+col and mem_wdata=In1_DATA.
REQ-008 SHALL advance fill counters col-inner (col 0..IMG_W-1, then row+1).
REQ-009 SHALL, on the ACK of pixel IMG_W*IMG_H-1, clear the counters and enter RD next cycle.
REQ-010 SHALL hold In1_ACK=0 and mem_we=0 outside FILL; In1_SEND in RD or EMIT is ignored.
REQ-011 SHALL drive mem_raddr=r*IMG_W+c from the drain counters; drain order is r-inner (r 0..IMG_H-1, then c+1).
REQ-012 SHALL spend exactly one cycle in RD, then enter EMIT; counters are held in both states so mem_rdata stays stable.
REQ-013 SHALL, in EMIT with Out1_RDY=1, assert Out1_SEND with Out1_DATA=mem_rdata, advance the drain counters, and go to RD, or to FILL after the last pixel.
REQ-014 SHALL remain in EMIT with Out1_SEND=0 while Out1_RDY=0, with no timeout.
REQ-015 SHALL assert frame_done with the Out1_SEND of the last pixel.
REQ-016 SHALL drive Out1_COUNT=16'h1 constantly.
REQ-017 SHALL drive Out1_DATA=0 whenever Out1_SEND=0.
REQ-018 SHALL make fill latency 1 pixel/cycle and drain latency 2 cycles/pixel minimum; a new frame's first ACK is possible the cycle after frame_done.
REQ-019 SHALL support IMG_W=1 and/or IMG_H=1 (degenerate frames pass through in input order).

Reset
REQ-020 SHALL, on RESET assertion at any time, including mid-fill or mid-drain, immediately force state FILL, all counters 0, and In1_ACK, Out1_SEND, mem_we, frame_done and busy to 0; the partial frame is discarded.
REQ-021 SHALL, after RESET release, accept the first ACK no earlier than the first rising CLK edge.

Configuration
REQ-022 SHALL, with TRANSPOSE_CTRL_FRAME_CNT_EN defined, add output frame_count (16 bits), reset 0, incremented on each frame_done and wrapping 0xFFFF->0.
REQ-023 SHALL, without TRANSPOSE_CTRL_FRAME_CNT_EN, omit the frame_count port and its register entirely; all other behaviour is identical.

Structure
REQ-024 SHALL place the FSM state enum (FILL/RD/EMIT) and the ADDR_W width-helper function in shared package transpose_pkg.
REQ-025 SHALL implement the 2-D wrap counter as sub-module transpose_ctrl_raster_cnt (inner/outer limits, enable, last flag), instantiated twice: fill and drain.

Verification
REQ-026 SHALL verify: 4x4 frame, In1_DATA 0..15 -> Out1_DATA 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; frame_done on the 16th send.
REQ-027 SHALL verify: IMG_W=3, IMG_H=2, input 0..5 -> output 0,3,1,4,2,5.
REQ-028 SHALL verify: Out1_RDY low for 10 cycles in EMIT at pixel 5 -> Out1_SEND held 0 and Out1_DATA=0 throughout; pixel 5's value is emitted when RDY returns; no pixel lost.
REQ-029 SHALL verify: RESET pulse after 7 fill pixels -> busy=0, In1_ACK=0; the next frame 100..115 transposes correctly with no stale data.
REQ-030 SHALL verify: two back-to-back frames with In1_SEND held high -> no ACK during drain; second-frame ACK exactly one cycle after the first frame_done.
REQ-031 SHALL verify, with TRANSPOSE_CTRL_FRAME_CNT_EN defined, 3 frames -> frame_count=3; preload 0xFFFF and complete 1 frame -> frame_count=0.
